// File: rtl/vga_pkg.sv
// Shared display geometry, colour type and sprite fetch FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;
    localparam int ACTIVE_COLS  = 640;
    localparam int ACTIVE_ROWS  = 480;
    localparam int H_BLANK_COLS = 160;
    localparam int V_BLANK_ROWS = 45;
    localparam int SPRITE_SIZE  = 32;
    localparam int SPR_W        = $clog2(SPRITE_SIZE);
    localparam int ADDR_W       = 2 * SPR_W;

    localparam int COLOR_W = 12;
    typedef logic [COLOR_W-1:0] color_t;

    localparam color_t BG_COLOR  = 12'h000;
    localparam color_t KEY_COLOR = 12'hF0F;

    typedef enum logic {
        IDLE,
        FETCH
    } sprite_fsm_t;
endpackage

// File: rtl/sprite_line_buffer.sv
// One sprite line of pixels: single write port, single registered read port.
// Latency: read data appears 1 cycle after the read index is presented.
// Backpressure: none; writes and reads are accepted every cycle.
module sprite_line_buffer
    import vga_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [SPR_W-1:0] i_wr_idx,
    input  color_t           i_wr_dat,
    input  logic [SPR_W-1:0] i_rd_idx,
    output color_t           o_rd_dat
);
    color_t mem_q [SPRITE_SIZE];
    color_t rd_dat_q;

    // Storage write and registered read; contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_idx] <= i_wr_dat;
        end
        rd_dat_q <= mem_q[i_rd_idx];
    end

    assign o_rd_dat = rd_dat_q;
endmodule

// File: rtl/sprite_renderer.sv
// Overlays one sprite on a fixed background and re-times syncs/DE/colour for the pins.
// Latency: 2 cycles from timing counters to every video output; line fetch runs cols 129..160.
// Backpressure: none; the memory must return data exactly 1 cycle after each read strobe.
module sprite_renderer
    import vga_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [9:0]        i_col_count,
    input  logic [9:0]        i_row_count,
    input  logic              i_hsync,
    input  logic              i_vsync,
    input  logic              i_sprite_x0,
    input  logic              i_sprite_y0,
    input  logic [9:0]        i_sprite_x,
    input  logic [9:0]        i_sprite_y,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  color_t            i_mem_data,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_de,
    output color_t            o_rgb
);
    sprite_fsm_t      state_q, state_d;
    logic [SPR_W-1:0] k_q, k_d;
    logic [SPR_W-1:0] line_q, line_d;
    logic             line_valid_q, line_valid_d;
    logic [9:0]       pos_x_q, pos_x_d;
    logic [9:0]       pos_y_q, pos_y_d;
    logic             wr_en_q, wr_en_d;
    logic [SPR_W-1:0] wr_idx_q, wr_idx_d;
    logic             de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d, inside1_q, inside1_d;
    logic             de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d;
    color_t           rgb_q, rgb_d;

    logic             row_ok, col_ok, line_hit;
    logic [10:0]      ar, ac, py_ext, px_ext;
    logic [SPR_W-1:0] line_sel, rd_idx;
    color_t           buf_rd;

    // Geometry: which sprite line this row needs and which buffer entry this column shows.
    // 11-bit compares keep pos + SPRITE_SIZE from wrapping.
    always_comb begin
        row_ok   = i_row_count >= 10'(V_BLANK_ROWS);
        col_ok   = i_col_count >= 10'(H_BLANK_COLS);
        ar       = {1'b0, i_row_count} - 11'(V_BLANK_ROWS);
        ac       = {1'b0, i_col_count} - 11'(H_BLANK_COLS);
        py_ext   = {1'b0, pos_y_q};
        px_ext   = {1'b0, pos_x_q};
        line_hit = row_ok && (ar >= py_ext) && (ar < py_ext + 11'(SPRITE_SIZE));
        line_sel = SPR_W'(ar - py_ext);
        rd_idx   = SPR_W'(ac - px_ext);
    end

    // Fetch FSM: on the column strobe, copy the hit line from sprite memory into the buffer.
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        line_d       = line_q;
        line_valid_d = line_valid_q;
        case (state_q)
            IDLE: begin
                if (i_sprite_x0) begin
                    line_valid_d = 1'b0;
                    k_d          = '0;
                    if (line_hit) begin
                        state_d = FETCH;
                        line_d  = line_sel;
                    end
                end
            end
            FETCH: begin
                k_d = k_q + 1'b1;
                if (k_q == SPR_W'(SPRITE_SIZE - 1)) begin
                    state_d      = IDLE;
                    line_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_mem_rd   = (state_q == FETCH);
    assign o_mem_addr = (state_q == FETCH) ? {line_q, k_q} : '0;

    // Position latch, buffer write timing and the two-stage video pipeline.
    // Stage 1 uses line_valid_d so the pixel at active column 0 sees the line that
    // finishes fetching in that same cycle.
    always_comb begin
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        if (i_sprite_y0 && (i_col_count == 10'd0)) begin
            pos_x_d = i_sprite_x;
            pos_y_d = i_sprite_y;
        end
        wr_en_d   = o_mem_rd;
        wr_idx_d  = k_q;
        de1_d     = col_ok && row_ok;
        hs1_d     = i_hsync;
        vs1_d     = i_vsync;
        inside1_d = line_valid_d && col_ok && (ac >= px_ext) && (ac < px_ext + 11'(SPRITE_SIZE));
        de2_d     = de1_q;
        hs2_d     = hs1_q;
        vs2_d     = vs1_q;
        rgb_d     = '0;
        if (de1_q) begin
            rgb_d = (inside1_q && (buf_rd != KEY_COLOR)) ? buf_rd : BG_COLOR;
        end
    end

    // State register for FSM, position and pipeline.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            k_q          <= '0;
            line_q       <= '0;
            line_valid_q <= 1'b0;
            pos_x_q      <= '0;
            pos_y_q      <= '0;
            wr_en_q      <= 1'b0;
            wr_idx_q     <= '0;
            de1_q        <= 1'b0;
            hs1_q        <= 1'b0;
            vs1_q        <= 1'b0;
            inside1_q    <= 1'b0;
            de2_q        <= 1'b0;
            hs2_q        <= 1'b0;
            vs2_q        <= 1'b0;
            rgb_q        <= '0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            line_q       <= line_d;
            line_valid_q <= line_valid_d;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            wr_en_q      <= wr_en_d;
            wr_idx_q     <= wr_idx_d;
            de1_q        <= de1_d;
            hs1_q        <= hs1_d;
            vs1_q        <= vs1_d;
            inside1_q    <= inside1_d;
            de2_q        <= de2_d;
            hs2_q        <= hs2_d;
            vs2_q        <= vs2_d;
            rgb_q        <= rgb_d;
        end
    end

    sprite_line_buffer u_line_buf (
        .i_clk    (i_clk),
        .i_wr_en  (wr_en_q),
        .i_wr_idx (wr_idx_q),
        .i_wr_dat (i_mem_data),
        .i_rd_idx (rd_idx),
        .o_rd_dat (buf_rd)
    );

    assign o_hsync = hs2_q;
    assign o_vsync = vs2_q;
    assign o_de    = de2_q;
    assign o_rgb   = rgb_q;
endmodule

// File: tb/tb_sprite_renderer.sv
// Randomized bench for sprite_renderer against a per-pixel reference model.
// Latency: model predicts video outputs 2 cycles after the counters it is given.
// Backpressure: n/a; the bench answers every memory read one cycle later.
module tb_sprite_renderer;
    import vga_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [9:0]        col, row;
    logic              hs, vs, x0, y0;
    logic [9:0]        sx, sy;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    color_t            mem_data;
    logic              o_hs, o_vs, o_de;
    color_t            o_rgb;

    always #20 clk = ~clk;

    sprite_renderer dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_col_count (col),
        .i_row_count (row),
        .i_hsync     (hs),
        .i_vsync     (vs),
        .i_sprite_x0 (x0),
        .i_sprite_y0 (y0),
        .i_sprite_x  (sx),
        .i_sprite_y  (sy),
        .o_mem_rd    (mem_rd),
        .o_mem_addr  (mem_addr),
        .i_mem_data  (mem_data),
        .o_hsync     (o_hs),
        .o_vsync     (o_vs),
        .o_de        (o_de),
        .o_rgb       (o_rgb)
    );

    typedef struct packed {
        logic   hs;
        logic   vs;
        logic   de;
        color_t rgb;
    } vid_t;

    color_t            rom [1024];
    vid_t              ring [4];
    logic [1:0]        cyc;
    int                nvec, nbad;
    int                m_px, m_py, m_line;
    bit                m_fetch_ok;
    logic              cap_rd;
    logic [ADDR_W-1:0] cap_addr;
    int                rd_count;

    task automatic check_eq(input string tag, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0d expected %0d (col %0d row %0d)", tag, got, exp, col, row);
        end
    endtask

    // One pixel clock: drive inputs, check outputs mid-cycle, advance the model.
    task automatic tick(input int c, input int r, input bit rst_now);
        vid_t   e, nxt;
        bit     exp_rd;
        int     ac, ar;
        color_t v;
        col      = 10'(c);
        row      = 10'(r);
        rst      = rst_now;
        x0       = (c == 128);
        y0       = (r == 13);
        hs       = 1'($urandom_range(0, 1));
        vs       = 1'($urandom_range(0, 1));
        mem_data = cap_rd ? rom[cap_addr] : color_t'($urandom);
        @(negedge clk);
        e = ring[cyc];
        check_eq("rgb",   int'(o_rgb), int'(e.rgb));
        check_eq("de",    int'(o_de),  int'(e.de));
        check_eq("hsync", int'(o_hs),  int'(e.hs));
        check_eq("vsync", int'(o_vs),  int'(e.vs));
        exp_rd = m_fetch_ok && (c >= 129) && (c <= 160);
        check_eq("mem_rd",   int'(mem_rd),   int'(exp_rd));
        check_eq("mem_addr", int'(mem_addr), exp_rd ? (m_line * 32 + c - 129) : 0);
        if (mem_rd) rd_count++;
        cap_rd   = mem_rd;
        cap_addr = mem_addr;
        // what the pins must show two cycles from now for this cycle's counters
        nxt.hs  = hs;
        nxt.vs  = vs;
        nxt.de  = (c >= 160) && (r >= 45);
        nxt.rgb = '0;
        if (nxt.de) begin
            ac      = c - 160;
            nxt.rgb = BG_COLOR;
            if (m_fetch_ok && (ac >= m_px) && (ac < m_px + 32)) begin
                v = rom[m_line * 32 + ac - m_px];
                if (v != KEY_COLOR) nxt.rgb = v;
            end
        end
        ring[cyc + 2'd2] = nxt;
        if (rst_now) begin
            ring[cyc + 2'd1] = '0;
            ring[cyc + 2'd2] = '0;
            m_fetch_ok = 1'b0;
            m_px = 0;
            m_py = 0;
        end else begin
            if (y0 && c == 0) begin
                m_px = int'(sx);
                m_py = int'(sy);
            end
            if (x0) begin
                ar         = r - 45;
                m_fetch_ok = (r >= 45) && (ar >= m_py) && (ar < m_py + 32);
                m_line     = ar - m_py;
            end
        end
        cyc = cyc + 2'd1;
        @(posedge clk);
        #1;
    endtask

    // A row skips columns 1..119, which the design never looks at.
    task automatic run_row(input int r, input int rst_col);
        tick(0, r, rst_col == 0);
        for (int c = 120; c < 800; c++) tick(c, r, c == rst_col);
    endtask

    task automatic rom_ramp();
        for (int a = 0; a < 1024; a++) rom[a] = color_t'(a);
    endtask

    task automatic rom_random();
        for (int a = 0; a < 1024; a++)
            rom[a] = ($urandom_range(0, 7) == 0) ? KEY_COLOR : color_t'($urandom);
    endtask

    initial begin
        int r;
        nvec = 0; nbad = 0; cyc = 2'd0;
        m_px = 0; m_py = 0; m_line = 0; m_fetch_ok = 1'b0;
        cap_rd = 1'b0; cap_addr = '0; rd_count = 0;
        for (int i = 0; i < 4; i++) ring[i] = '0;
        rst = 1'b1; col = '0; row = '0; hs = 1'b0; vs = 1'b0;
        x0 = 1'b0; y0 = 1'b0; sx = '0; sy = '0; mem_data = '0;
        repeat (3) @(posedge clk);
        #1;
        tick(0, 0, 1'b1);
        tick(0, 0, 1'b1);

        // sprite at the origin, ramp contents
        rom_ramp(); sx = 10'd0; sy = 10'd0;
        run_row(13, -1);
        foreach (r_list_a[i]) run_row(r_list_a[i], -1);

        // sprite at (100,200): full-frame read count
        rom_random(); sx = 10'd100; sy = 10'd200;
        run_row(13, -1);
        rd_count = 0;
        for (int rr = 244; rr <= 277; rr++) run_row(rr, -1);
        check_eq("reads_per_frame", rd_count, 1024);

        // transparency at entry 5
        rom_ramp(); rom[5] = KEY_COLOR; sx = 10'd10; sy = 10'd0;
        run_row(13, -1);
        run_row(45, -1);

        // position change mid-frame is deferred to the next latch
        rom_random(); sx = 10'd50; sy = 10'd60;
        run_row(13, -1);
        sx = 10'd300;
        run_row(100, -1);
        run_row(110, -1);
        run_row(136, -1);
        run_row(13, -1);
        run_row(110, -1);

        // reset in the middle of a fetch
        rom_random(); sx = 10'd0; sy = 10'd0;
        run_row(13, -1);
        run_row(49, -1);
        run_row(50, 140);
        run_row(51, -1);

        // right-edge clip
        rom_ramp(); sx = 10'd620; sy = 10'd0;
        run_row(13, -1);
        run_row(45, -1);
        run_row(46, -1);

        // random frames with random positions, contents and late position changes
        for (int f = 0; f < 4; f++) begin
            rom_random();
            sx = 10'($urandom_range(0, 639));
            sy = 10'($urandom_range(0, 479));
            run_row(13, -1);
            sx = 10'($urandom_range(0, 639));
            for (int j = 0; j < 5; j++) begin
                r = 45 + m_py + int'($urandom_range(0, 37)) - 3;
                if (r < 14) r = 14;
                if (r > 524) r = 524;
                run_row(r, -1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

    int r_list_a [5] = '{44, 45, 46, 76, 77};
endmodule

// File: doc/sprite_renderer.md
# sprite_renderer

Consumes the VGA timing counters and strobes and produces the final delayed sync, data-enable and pixel colour for the 640x480 display. It draws one SPRITE_SIZE x SPRITE_SIZE sprite over a fixed background. Each sprite line is prefetched from an external synchronous sprite memory into an on-chip line buffer during the SPRITE_SIZE-column window that ends when the active columns begin. It sits directly downstream of the VGA timing generator and drives the DAC/pins.

## Interface
- ACTIVE_COLS, 640, visible columns
- ACTIVE_ROWS, 480, visible rows
- H_BLANK_COLS, 160, leading non-active columns per line (active when col ≥ this)
- V_BLANK_ROWS, 45, leading non-active rows per frame (active when row ≥ this)
- SPRITE_SIZE, 32, sprite width/height in pixels (power of two)
- COLOR_W, 12, pixel colour width
- BG_COLOR, 12'h000, background colour
- KEY_COLOR, 12'hF0F, transparent colour key

Ports:
- i_clk  in  1  pixel clock (25 MHz)
- i_reset  in  1  synchronous, active-high reset
- i_col_count  in  10  current column from timing generator
- i_row_count  in  10  current row from timing generator
- i_hsync, i_vsync  in  1  timing-generator syncs
- i_sprite_x0  in  1  one-cycle strobe, col == H_BLANK_COLS − SPRITE_SIZE
- i_sprite_y0  in  1  one-cycle strobe per column of row V_BLANK_ROWS − SPRITE_SIZE
- i_sprite_x, i_sprite_y  in  10  sprite top-left in active-area coordinates
- o_mem_rd  out  1  sprite-memory read strobe
- o_mem_addr  out  log2(SPRITE_SIZE²)  read address, line*SPRITE_SIZE + k
- i_mem_data  in  COLOR_W  read data, valid exactly 1 cycle after o_mem_rd
- o_hsync, o_vsync, o_de  out  1  syncs and data-enable, delayed 2 cycles
- o_rgb  out  COLOR_W  pixel colour, aligned with o_de

## Operation
- Position latch: pos_x/pos_y ← i_sprite_x/i_sprite_y on any cycle with i_sprite_y0 && col == 0. They are stable for the whole frame, so no tearing.
- Line select: ar = i_row_count − V_BLANK_ROWS. A line hits when row ≥ V_BLANK_ROWS and pos_y ≤ ar < pos_y + SPRITE_SIZE. Compare at 11 bits so there is no wrap. line = ar − pos_y (log2 SPRITE_SIZE bits).
- FSM states are IDLE and FETCH.
  - IDLE → FETCH on i_sprite_x0 when the line hits. k ← 0, line_valid ← 0.
  - IDLE on i_sprite_x0 when the line misses: line_valid ← 0, stay IDLE.
  - FETCH issues o_mem_rd = 1 with addr line*SPRITE_SIZE + k for k = 0..SPRITE_SIZE−1, one per cycle.
  - After the last read: → IDLE and set line_valid.
- Line buffer: write buf[k] ← i_mem_data one cycle after each read.
- Pixel path, per active column: ac = col − H_BLANK_COLS. Inside = line_valid && pos_x ≤ ac < pos_x + SPRITE_SIZE (11-bit compare). A pixel beyond ac = 639 is never shown; there is no wrap to the next line.
- Colour selection: o_rgb = buf[ac − pos_x] if inside and that value ≠ KEY_COLOR. Otherwise o_rgb = BG_COLOR. o_rgb = 0 whenever o_de = 0.
- o_de = (col ≥ H_BLANK_COLS) && (row ≥ V_BLANK_ROWS), delayed.

## Timing
- Reset values: state IDLE, k 0, line_valid 0, pos_x/pos_y 0, o_mem_rd 0, o_mem_addr 0, o_hsync/o_vsync/o_de 0, o_rgb 0. Line-buffer contents are not reset.
- Fetch timing: strobe at col 128. First o_mem_rd at col 129. Last read at col 160. Last buffer write at col 161.
- Sprite pixel k is first consumed at col 160 + pos_x + k, which is never before its write. Requirement: write of buf[k] lands no later than the cycle before its read.
- Output latency: exactly 2 cycles from the input counters to every output.
  - Stage 1: register ac, inside, de, syncs; registered buffer read.
  - Stage 2: key/background mux.
- i_sprite_x0 while in FETCH: ignored.
- Reset mid-fetch: o_mem_rd = 0 from the next cycle, line_valid = 0, the rest of that line is background. The next hitting line fetches normally.
- Position change mid-frame: takes effect only at the next i_sprite_y0 latch.

## Structure
- Package vga_pkg holds:
  - COLOR_W and color_t;
  - the sprite_fsm_t enum {IDLE, FETCH};
  - shared timing constants 640/480/160/45/32.
- Sub-module sprite_line_buffer holds SPRITE_SIZE × COLOR_W storage with one write port and one registered read port (1-cycle latency).

## Test plan
- Sprite at (0,0), ROM[a] = a:
  - row 45, col 160 → o_rgb = 0 two cycles later;
  - col 191 → 31;
  - col 192 → BG_COLOR;
  - o_de rises 2 cycles after col 160.
- Sprite at (100,200):
  - o_mem_rd asserts for exactly 32 consecutive cycles (cols 129–160) on rows 245–276 only;
  - addresses run 0..1023 in order;
  - 1024 reads per frame.
- Transparency: ROM[5] = KEY_COLOR with sprite at (10,0) → active column 15 of row 45 outputs BG_COLOR; columns 14 and 16 output ROM data.
- Mid-frame move: i_sprite_x changes 50 → 300 at row 100 → sprite stays at x = 50 until the next frame, then moves to x = 300.
- Reset pulse at col 140 of a hitting line:
  - o_mem_rd = 0 next cycle, all outputs return to their reset values;
  - the remainder of the line is background;
  - the following line draws correctly.
- Right-edge clip at (620,0): active columns 620–639 show ROM 0–19; the next line's active column 0 shows BG_COLOR.
